// File: rtl/multi_countdown_timer.sv
// Multi-channel mm:ss BCD countdown timer; all channels share one 1 s prescaler.
// Define TIMER_PRESET_RELOAD_EN to keep a per-channel preset that is reloaded on start in DONE.
module multi_countdown_timer #(
  parameter int CHANNELS = 2,
  parameter int TICK_DIV = 5000000,
  parameter int SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SEL_W-1:0]    sel,
  input  logic                cfg,
  input  logic                start,
  input  logic                clear,
  input  logic                inc_min,
  input  logic                inc_sec,
  output logic [15:0]         disp_bcd,
  output logic [CHANNELS-1:0] running,
  output logic [CHANNELS-1:0] done,
  output logic                alarm
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [2:0] {S_IDLE, S_CONFIG, S_PAUSED, S_RUNNING, S_DONE} state_t;

  state_t              r_state [CHANNELS];
  logic [15:0]         r_val   [CHANNELS];
`ifdef TIMER_PRESET_RELOAD_EN
  logic [15:0]         r_preset[CHANNELS];
`endif
  logic [CHANNELS-1:0] r_done;
  logic [PW-1:0]       r_presc;
  logic                w_tick;
  logic [CHANNELS-1:0] w_hit;

  // Value layout is {min_tens, min_ones, sec_tens, sec_ones}; every step stays in legal BCD.
  function automatic logic [15:0] f_cfg_inc(input logic [15:0] v, input logic im, input logic is);
    logic [15:0] n;
    n = v;
    if (is) begin
      if (v[7:0] == 8'h59) n[7:0] = 8'h00;
      else if (v[3:0] == 4'd9) begin
        n[7:4] = v[7:4] + 4'd1;
        n[3:0] = 4'd0;
      end else n[3:0] = v[3:0] + 4'd1;
    end
    if (im) begin
      if (v[15:8] == 8'h99) n[15:8] = 8'h00;
      else if (v[11:8] == 4'd9) begin
        n[15:12] = v[15:12] + 4'd1;
        n[11:8]  = 4'd0;
      end else n[11:8] = v[11:8] + 4'd1;
    end
    return n;
  endfunction

  function automatic logic [15:0] f_dec(input logic [15:0] v);
    logic [15:0] n;
    n = v;
    if (v[3:0] != 4'd0) n[3:0] = v[3:0] - 4'd1;
    else if (v[7:4] != 4'd0) begin
      n[7:4] = v[7:4] - 4'd1;
      n[3:0] = 4'd9;
    end else if (v[15:8] != 8'h00) begin
      n[7:0] = 8'h59;
      if (v[11:8] != 4'd0) n[11:8] = v[11:8] - 4'd1;
      else begin
        n[15:12] = v[15:12] - 4'd1;
        n[11:8]  = 4'd9;
      end
    end
    return n;
  endfunction

  assign w_tick = (r_presc == PW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_presc <= '0;
    else if (w_tick) r_presc <= '0;
    else r_presc <= r_presc + PW'(1);
  end

  // Out-of-range sel values match no channel.
  always_comb begin
    w_hit = '0;
    for (int c = 0; c < CHANNELS; c++)
      if (32'(sel) == c) w_hit[c] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < CHANNELS; c++) begin
        r_state[c]  <= S_IDLE;
        r_val[c]    <= '0;
`ifdef TIMER_PRESET_RELOAD_EN
        r_preset[c] <= '0;
`endif
      end
      r_done <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (w_hit[c] && clear) begin
          r_state[c] <= S_IDLE;
          r_val[c]   <= '0;
          r_done[c]  <= 1'b0;
        end else begin
          case (r_state[c])
            S_IDLE: if (w_hit[c] && cfg) r_state[c] <= S_CONFIG;
            S_CONFIG: if (w_hit[c]) begin
              if (!cfg) begin
                r_state[c]  <= S_PAUSED;
`ifdef TIMER_PRESET_RELOAD_EN
                r_preset[c] <= r_val[c];
`endif
              end else r_val[c] <= f_cfg_inc(r_val[c], inc_min, inc_sec);
            end
            S_PAUSED: begin
              if (w_hit[c] && cfg) r_state[c] <= S_CONFIG;
              else if (w_hit[c] && start && (r_val[c] != 16'h0000)) r_state[c] <= S_RUNNING;
            end
            S_RUNNING: begin
              if (w_hit[c] && cfg) r_state[c] <= S_CONFIG;
              else if (w_hit[c] && start) r_state[c] <= S_PAUSED;
              else if (w_tick) begin
                r_val[c] <= f_dec(r_val[c]);
                if (f_dec(r_val[c]) == 16'h0000) begin
                  r_state[c] <= S_DONE;
                  r_done[c]  <= 1'b1;
                end
              end
            end
            S_DONE: begin
              if (w_hit[c] && cfg) begin
                r_state[c] <= S_CONFIG;
                r_done[c]  <= 1'b0;
              end else if (w_hit[c] && start) begin
`ifdef TIMER_PRESET_RELOAD_EN
                r_state[c] <= S_PAUSED;
                r_val[c]   <= r_preset[c];
`else
                r_state[c] <= S_IDLE;
                r_val[c]   <= '0;
`endif
                r_done[c]  <= 1'b0;
              end
            end
            default: r_state[c] <= S_IDLE;
          endcase
        end
      end
    end
  end

  always_comb begin
    disp_bcd = '0;
    running  = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (w_hit[c]) disp_bcd = r_val[c];
      running[c] = (r_state[c] == S_RUNNING);
    end
  end

  assign done  = r_done;
  assign alarm = |r_done;

endmodule

// File: doc/multi_countdown_timer.md
# multi_countdown_timer

Parametrised multi-channel kitchen countdown timer core. It holds CHANNELS independent mm:ss BCD countdowns that share one internal 1 s prescaler. Each channel has its own config/pause/run/done state machine, and all channels are driven from one set of debounced button pulses plus a channel select. It sits between the debounce blocks and the 7-segment driver, and replaces the single-channel timer and FSM glue at the top level.

## Interface
- CHANNELS, 2, number of independent timers (1–8)
- TICK_DIV, 5000000, clk cycles per countdown second (≥2)
- SEL_W, max(1, clog2(CHANNELS)), width of `sel`
- clk  in  1  system clock (5 MHz domain)
- rst  in  1  asynchronous, active-low reset
- sel  in  SEL_W  channel addressed by cfg/start/clear/inc_*; values ≥CHANNELS address nothing
- cfg  in  1  level; config mode for selected channel
- start  in  1  single-cycle pulse; run/pause toggle and done acknowledge
- clear  in  1  single-cycle pulse; zero the selected channel
- inc_min  in  1  single-cycle pulse; +1 minute in CONFIG
- inc_sec  in  1  single-cycle pulse; +1 second in CONFIG
- disp_bcd  out  16  {min_tens, min_ones, sec_tens, sec_ones} of selected channel; 0 if sel invalid
- running  out  CHANNELS  channel in RUNNING
- done  out  CHANNELS  sticky, channel reached 00:00 while running
- alarm  out  1  OR of done

## Operation
- Prescaler: free-running 0..TICK_DIV-1; `tick` is high for one cycle when the count equals TICK_DIV-1. It is shared by all channels.
- Per-channel states: IDLE, CONFIG, PAUSED, RUNNING, DONE. Only the selected channel sees the controls. All channels see `tick`.
- Per-cycle priority for the selected channel: clear > cfg > start > inc/tick.
- clear (any state): go to IDLE; value 00:00; done=0.
- IDLE: cfg → CONFIG.
- CONFIG:
  - inc_sec sets ss+1, and 59 wraps to 00 with no carry.
  - inc_min sets mm+1, and 99 wraps to 00.
  - inc_min and inc_sec in the same cycle are both applied.
  - cfg low → PAUSED.
  - tick is ignored.
- PAUSED:
  - cfg → CONFIG with the value kept.
  - start → RUNNING if the value ≠ 00:00; otherwise start is ignored.
- RUNNING:
  - tick decrements in BCD: ss>0 gives ss-1; ss=00 with mm>0 gives mm-1, ss=59.
  - The tick that produces 00:00 also sets state DONE and done=1 on the same edge.
  - start → PAUSED. A tick in the same cycle is dropped for that channel.
  - cfg → CONFIG with the value kept.
- DONE: value 00:00; done=1; start → IDLE, which clears done; cfg → CONFIG, which clears done.
- Changing `sel` while in CONFIG leaves the old channel in CONFIG until it is reselected with cfg low.
- BCD digits are always legal: ss in 00–59, mm in 00–99. No binary intermediate is used.

## Timing
- Reset (rst=0, asynchronous): prescaler 0; all channels IDLE at 00:00; disp_bcd=0, running=0, done=0, alarm=0.
- The first tick occurs TICK_DIV cycles after rst deasserts.
- Control inputs are sampled on the rising edge of clk. The resulting state and value are visible the following cycle.
- disp_bcd is a combinational mux of registered channel values selected by `sel`, so a sel change is reflected in the same cycle.
- running, done and alarm are registered or derived only from registers. alarm has no extra latency relative to done.
- The first second after start lasts between 1 and TICK_DIV cycles, because the prescaler is not restarted.
- Reset asserted mid-run forces the reset values immediately; no count is retained.

## Configuration
- TIMER_PRESET_RELOAD_EN defined:
  - Each channel holds a preset register loaded with its value on the CONFIG → PAUSED edge.
  - start in DONE goes to PAUSED with the preset reloaded and done cleared.
  - clear keeps the preset.
  - Reset zeroes the preset.
- TIMER_PRESET_RELOAD_EN undefined: there is no preset storage, and start in DONE goes to IDLE at 00:00.

## Test plan
Benches use CHANNELS=2 and TICK_DIV=4.
- **Reset:** rst low mid-activity → all outputs 0 the same cycle; rst high → the first tick occurs 4 cycles later.
- **Basic countdown:** ch0 cfg, inc_min×1, inc_sec×5, cfg low, start → disp 0105. After 5 ticks disp 0100; the 6th tick gives 0059. The 65th tick gives 0000 with done[0]=1, alarm=1, running[0]=0. A further start → IDLE, done[0]=0.
- **Wrap and no-start:**
  - inc_sec×60 → ss 00, mm unchanged.
  - inc_min×100 → mm 00.
  - start at 00:00 in PAUSED → stays PAUSED, running=0.
- **Pause and priority:**
  - start while RUNNING at 0030 → PAUSED; 10 ticks → still 0030; start → resumes.
  - start coincident with a tick at 0001 → PAUSED at 0001, done=0.
- **Two channels:** ch0=0010, ch1=0003, both running. Toggling sel switches disp_bcd the same cycle. done[1] asserts at tick 3 and done[0] at tick 10, independently. clear on ch1 leaves ch0 unaffected.
- **Preset reload (TIMER_PRESET_RELOAD_EN defined):** after ch0 reaches done from 0105, start → PAUSED at 0105. Without the macro, start → IDLE at 0000.
